// File: rtl/wb_master_core.sv
// rtl/wb_master_core.sv - single-outstanding Wishbone B3 classic-cycle master (optional timeout: WB_MASTER_TIMEOUT_EN)
module wb_master_core #(
    parameter int TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t      state, state_nx;
    logic        ready_nx, cyc_nx, stb_nx, we_nx, rsp_valid_nx, rsp_err_nx;
    logic [3:0]  sel_nx;
    logic [31:0] adr_nx, dat_nx, rsp_dat_nx;
    logic        timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt, cnt_nx;

    // Abort only when the slave gives neither ack nor err on the final allowed edge
    assign timeout_hit = !wb_ack_i && !wb_err_i && (cnt == CW'(TIMEOUT - 1));

    // Cycle counter for the BUS wait
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) cnt <= '0;
        else             cnt <= cnt_nx;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // State and all outputs are registered so no input reaches an output combinationally
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            state       <= state_nx;
            cmd_ready_o <= ready_nx;
            wb_cyc_o    <= cyc_nx;
            wb_stb_o    <= stb_nx;
            wb_we_o     <= we_nx;
            wb_sel_o    <= sel_nx;
            wb_adr_o    <= adr_nx;
            wb_dat_o    <= dat_nx;
            rsp_valid_o <= rsp_valid_nx;
            rsp_err_o   <= rsp_err_nx;
            rsp_dat_o   <= rsp_dat_nx;
        end
    end

    // Next-state and next-output logic; bus fields hold their values unless a command is taken
    always_comb begin
        state_nx     = state;
        cyc_nx       = wb_cyc_o;
        stb_nx       = wb_stb_o;
        we_nx        = wb_we_o;
        sel_nx       = wb_sel_o;
        adr_nx       = wb_adr_o;
        dat_nx       = wb_dat_o;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = rsp_err_o;
        rsp_dat_nx   = rsp_dat_o;
`ifdef WB_MASTER_TIMEOUT_EN
        cnt_nx       = cnt;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_nx    = cmd_we_i;
                    sel_nx   = cmd_sel_i;
                    adr_nx   = cmd_adr_i;
                    dat_nx   = cmd_dat_i;
                    cyc_nx   = 1'b1;
                    stb_nx   = 1'b1;
                    state_nx = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            BUS: begin
                if (wb_ack_i || wb_err_i || timeout_hit) begin
                    cyc_nx       = 1'b0;
                    stb_nx       = 1'b0;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = wb_err_i || timeout_hit;
                    // err wins over a simultaneous ack, so data is only taken on a clean ack
                    if (!wb_we_o && wb_ack_i && !wb_err_i) rsp_dat_nx = wb_dat_i;
                    state_nx     = IDLE;
                end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                    cnt_nx = cnt + 1'b1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
        ready_nx = (state_nx == IDLE);
    end

endmodule

// File: tb/tb_wb_master_core.sv
// tb/tb_wb_master_core.sv - self-checking bench for wb_master_core (timeout checks under WB_MASTER_TIMEOUT_EN)
module tb_wb_master_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack, err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] model_dat;

    always #5 clk = ~clk;

    wb_master_core #(.TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
        .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
        .wb_ack_i(ack), .wb_err_i(err)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        int          term;     // 0 ack, 1 err, 2 ack+err
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                           input logic [3:0] t_sel, input int waits, input int term,
                           input logic [31:0] rdata, input logic [31:0] exp_dat, input logic exp_err);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = t_we; cmd_adr = t_adr; cmd_dat = t_dat; cmd_sel = t_sel;
        dat_i = rdata;
        ack = (waits == 0) && (term != 1);
        err = (waits == 0) && (term != 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we = ~t_we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        chk("cyc_on", {31'd0, cyc}, 32'd1);
        chk("stb_on", {31'd0, stb}, 32'd1);
        chk("we", {31'd0, we}, {31'd0, t_we});
        chk("adr", adr, t_adr);
        chk("dat_o", dat_o, t_dat);
        chk("sel", {28'd0, sel}, {28'd0, t_sel});
        chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wait_cyc", {31'd0, cyc}, 32'd1);
            chk("wait_adr", adr, t_adr);
            chk("wait_dat", dat_o, t_dat);
            chk("wait_sel", {28'd0, sel}, {28'd0, t_sel});
            chk("wait_ready", {31'd0, cmd_ready}, 32'd0);
            chk("wait_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        cmd_valid = 1'b0;
        ack = (term != 1);
        err = (term != 0);
        @(negedge clk);
        chk("cyc_off", {31'd0, cyc}, 32'd0);
        chk("stb_off", {31'd0, stb}, 32'd0);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("adr_held", adr, t_adr);
        ack = 1'b0; err = 1'b0;
        @(negedge clk);
        chk("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("idle_cyc", {31'd0, cyc}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'hAABBCCDD, 32'h0,        4'hF, 0, 0, 32'h33445566, 32'h33445566, 1'b0};
        vecs[1] = '{1'b1, 32'hAAAA5555, 32'h01010202, 4'hF, 0, 0, 32'hDEADBEEF, 32'h33445566, 1'b0};
        vecs[2] = '{1'b0, 32'h00001000, 32'h0,        4'h3, 3, 0, 32'h12345678, 32'h12345678, 1'b0};
        vecs[3] = '{1'b0, 32'h00002000, 32'h0,        4'hF, 0, 2, 32'hCAFEF00D, 32'h12345678, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        dat_i = '0; ack = 1'b0; err = 1'b0;

        // reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);
        chk("rst_sel_we", {27'd0, sel, we}, 32'd0);
        chk("rst_rsp", {rsp_dat[29:0], rsp_valid, rsp_err}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_pre_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("ready_post_edge", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_cyc", {31'd0, cyc}, 32'd0);

        // directed table
        for (int v = 0; v < 4; v++)
            run_txn(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, vecs[v].waits,
                    vecs[v].term, vecs[v].rdata, vecs[v].exp_dat, vecs[v].exp_err);
        model_dat = vecs[3].exp_dat;

        // random transactions against the reference model
        for (int k = 0; k < 40; k++) begin
            logic        r_we;
            logic [31:0] r_adr, r_dat, r_rd;
            logic [3:0]  r_sel;
            int          r_w, r_t;
            r_we = 1'($urandom_range(0, 1)); r_adr = $urandom; r_dat = $urandom; r_rd = $urandom;
            r_sel = 4'($urandom); r_w = $urandom_range(0, 4); r_t = $urandom_range(0, 2);
            if (!r_we && r_t == 0) model_dat = r_rd;
            run_txn(r_we, r_adr, r_dat, r_sel, r_w, r_t, r_rd, model_dat, r_t != 0);
        end

        // reset in the middle of a bus cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h5A5A0000; cmd_sel = 4'hF; ack = 1'b0; err = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_cyc_on", {31'd0, cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", {31'd0, cyc}, 32'd0);
        chk("mid_rst_stb", {31'd0, stb}, 32'd0);
        chk("mid_rst_adr", adr, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ack = 1'b1; dat_i = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("mid_no_cyc", {31'd0, cyc}, 32'd0);
        end
        chk("mid_rsp_dat", rsp_dat, 32'd0);
        ack = 1'b0;
        model_dat = 32'd0;

        // slave that never answers
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000BEEF; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        begin
            int cycles;
            cycles = 0;
            while (cyc && cycles < 100) begin
                cycles++;
                @(negedge clk);
            end
            chk("timeout_cycles", cycles, 32'd16);
            chk("timeout_rsp", {31'd0, rsp_valid}, 32'd1);
            chk("timeout_err", {31'd0, rsp_err}, 32'd1);
            chk("timeout_dat", rsp_dat, model_dat);
        end
`else
        for (int i = 0; i < 20; i++) begin
            chk("no_timeout_cyc", {31'd0, cyc}, 32'd1);
            @(negedge clk);
        end
        dat_i = 32'h0BADCAFE; ack = 1'b1;
        @(negedge clk);
        chk("late_ack_rsp", {31'd0, rsp_valid}, 32'd1);
        chk("late_ack_dat", rsp_dat, 32'h0BADCAFE);
        ack = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
